adc_uart_packetizer: RTL and testbench

ADC_UART_PACKETIZER -- requirements
Module: adc_uart_packetizer

---
 rtl/adc_uart_packetizer.sv | 210 +++++++++++++++++++++
 tb/tb_adc_uart_packetizer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_uart_packetizer.sv
// Buffers ADC capture bytes in a FIFO and frames them as HEADER/seq/LEN/payload packets for uart_tx.
// Define PKT_CHECKSUM_EN to append a modulo-256 checksum byte to every packet.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | wait for a full packet's worth of data or a served flush
// S_HDR     | issue HEADER byte
// S_SEQ     | issue sequence number
// S_LEN     | issue frozen payload length
// S_PAYLOAD | issue and pop LEN FIFO bytes
// S_CSUM    | issue checksum (PKT_CHECKSUM_EN builds only)
module adc_uart_packetizer #(
  parameter int          PKT_LEN    = 16,
  parameter int          FIFO_DEPTH = 32,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        tx_wreq,
  output logic [7:0]  tx_wdata,
  input  logic        tx_rdy,
  output logic        overflow,
  output logic [15:0] pkt_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PKT_LVL  = LW'(PKT_LEN);

`ifdef PKT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_LEN, S_PAYLOAD, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_LEN, S_PAYLOAD} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      len_q, len_d, rem_q, rem_d, seq_q, seq_d;
  logic [7:0]      tx_wdata_q, tx_wdata_d;
  logic [1:0]      guard_q, guard_d;
  logic            flush_pend_q, flush_pend_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic       push, pop, fire, pkt_done;
  logic [7:0] byte_now;

  assign in_ready = !rst && (level_q != FULL_LVL);
  assign push     = in_valid && in_ready;
  // A byte goes out only while framing, with uart_tx idle and the post-write guard expired.
  assign fire     = !rst && (state_q != S_IDLE) && tx_rdy && (guard_q == 2'd0);
  assign pop      = fire && (state_q == S_PAYLOAD);

  assign tx_wreq  = fire;
  assign tx_wdata = rst ? 8'h00 : (fire ? byte_now : tx_wdata_q);
  assign overflow = overflow_q;
  assign pkt_cnt  = pkt_cnt_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    len_d        = len_q;
    rem_d        = rem_q;
    seq_d        = seq_q;
    guard_d      = guard_q;
    flush_pend_d = flush_pend_q | flush;
    overflow_d   = overflow_q | (in_valid && !in_ready);
    pkt_cnt_d    = pkt_cnt_q;
    byte_now     = 8'h00;
    pkt_done     = 1'b0;
`ifdef PKT_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (fire)                 guard_d = 2'd2;
    else if (guard_q != 2'd0) guard_d = guard_q - 2'd1;

    case (state_q)
      S_IDLE: begin
        if (level_q >= PKT_LVL) begin
          len_d        = 8'(PKT_LEN);
          rem_d        = 8'(PKT_LEN);
          flush_pend_d = 1'b0;
          state_d      = S_HDR;
        end else if (flush_pend_q || flush) begin
          // level < PKT_LEN here, so level is already min(level, PKT_LEN); empty flush is dropped
          flush_pend_d = 1'b0;
          if (level_q != '0) begin
            len_d   = 8'(level_q);
            rem_d   = 8'(level_q);
            state_d = S_HDR;
          end
        end
`ifdef PKT_CHECKSUM_EN
        csum_d = 8'h00;
`endif
      end
      S_HDR: begin
        byte_now = HEADER;
        if (fire) state_d = S_SEQ;
      end
      S_SEQ: begin
        byte_now = seq_q;
        if (fire) begin
          state_d = S_LEN;
`ifdef PKT_CHECKSUM_EN
          csum_d  = csum_q + seq_q;
`endif
        end
      end
      S_LEN: begin
        byte_now = len_q;
        if (fire) begin
          state_d = S_PAYLOAD;
`ifdef PKT_CHECKSUM_EN
          csum_d  = csum_q + len_q;
`endif
        end
      end
      S_PAYLOAD: begin
        byte_now = mem_q[rd_ptr_q];
        if (fire) begin
          rem_d = rem_q - 8'd1;
`ifdef PKT_CHECKSUM_EN
          csum_d = csum_q + byte_now;
          if (rem_q == 8'd1) state_d = S_CSUM;
`else
          if (rem_q == 8'd1) pkt_done = 1'b1;
`endif
        end
      end
`ifdef PKT_CHECKSUM_EN
      S_CSUM: begin
        byte_now = csum_q;
        if (fire) pkt_done = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (pkt_done) begin
      state_d   = S_IDLE;
      seq_d     = seq_q + 8'd1;
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    tx_wdata_d = fire ? byte_now : tx_wdata_q;
  end

  always_ff @(posedge clk_50M) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      len_q        <= 8'h00;
      rem_q        <= 8'h00;
      seq_q        <= 8'h00;
      tx_wdata_q   <= 8'h00;
      guard_q      <= 2'd0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      pkt_cnt_q    <= 16'h0000;
`ifdef PKT_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      seq_q        <= seq_d;
      tx_wdata_q   <= tx_wdata_d;
      guard_q      <= guard_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
      pkt_cnt_q    <= pkt_cnt_d;
`ifdef PKT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_uart_packetizer.sv
// Directed self-checking bench for adc_uart_packetizer; follows PKT_CHECKSUM_EN to expect the trailing checksum.
module tb_adc_uart_packetizer;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        tx_wreq;
  logic [7:0]  tx_wdata;
  logic        tx_rdy = 1'b1;
  logic        overflow;
  logic [15:0] pkt_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_wreq = -100;
  logic [7:0] last_wdata = 8'h00;
  bit mon_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] pay[$];

  adc_uart_packetizer dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .flush   (flush),
    .tx_wreq (tx_wreq),
    .tx_wdata(tx_wdata),
    .tx_rdy  (tx_rdy),
    .overflow(overflow),
    .pkt_cnt (pkt_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Captures every written byte and checks handshake rules each cycle.
  always @(negedge clk_50M) begin
    cyc++;
    if (mon_en) begin
      if (rst) begin
        chk("rst_wreq", {31'd0, tx_wreq}, 32'd0);
        chk("rst_wdata", {24'd0, tx_wdata}, 32'd0);
        last_wdata = 8'h00;
        last_wreq  = -100;
      end else if (tx_wreq) begin
        chk("wreq_needs_rdy", {31'd0, tx_rdy}, 32'd1);
        chk("guard_gap", {31'd0, (cyc - last_wreq) >= 3}, 32'd1);
        last_wreq  = cyc;
        last_wdata = tx_wdata;
        rx_q.push_back(tx_wdata);
      end else begin
        chk("wdata_hold", {24'd0, tx_wdata}, {24'd0, last_wdata});
      end
    end
  end

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rx_timeout", {31'd0, rx_q.size() >= n}, 32'd1);
  endtask

  // Expected packet built from the payload queue; checksum covers seq, LEN and payload.
  task automatic expect_pkt(input logic [7:0] seqv, input string name);
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seqv);
    exp_q.push_back(8'(pay.size()));
    sum = seqv + 8'(pay.size());
    foreach (pay[i]) begin
      exp_q.push_back(pay[i]);
      sum = sum + pay[i];
    end
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    wait_rx(exp_q.size(), 3000);
    foreach (exp_q[i]) begin
      if (rx_q.size() > 0) begin
        chk($sformatf("%s_b%0d", name, i), {24'd0, rx_q[0]}, {24'd0, exp_q[i]});
        void'(rx_q.pop_front());
      end
    end
  endtask

  initial begin
    // reset
    rst = 1'b1;
    ticks(2);
    mon_en = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_tx_wreq", {31'd0, tx_wreq}, 32'd0);
    chk("rst_tx_wdata", {24'd0, tx_wdata}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("post_rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);

    // full packet 0x00..0x0F
    pay.delete();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      pay.push_back(8'(i));
    end
    expect_pkt(8'd0, "full0");
    ticks(3);
    chk("pkt_cnt_1", {16'd0, pkt_cnt}, 32'd1);

    // partial packet via flush
    pay.delete();
    push_byte(8'hC1); push_byte(8'h02); push_byte(8'h03);
    pay.push_back(8'hC1); pay.push_back(8'h02); pay.push_back(8'h03);
    ticks(10);
    chk("no_tx_before_flush", rx_q.size(), 32'd0);
    pulse_flush();
    expect_pkt(8'd1, "flush3");
    ticks(3);
    chk("pkt_cnt_2", {16'd0, pkt_cnt}, 32'd2);

    // flush arriving mid-packet is served at the next IDLE
    pay.delete();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(8'h60 + i));
      pay.push_back(8'(8'h60 + i));
    end
    ticks(4);
    push_byte(8'h70);
    push_byte(8'h71);
    pulse_flush();
    expect_pkt(8'd2, "pre_latched");
    pay.delete();
    pay.push_back(8'h70); pay.push_back(8'h71);
    expect_pkt(8'd3, "latched_flush");

    // flush with empty FIFO is dropped
    ticks(5);
    pulse_flush();
    ticks(20);
    chk("empty_flush_silent", rx_q.size(), 32'd0);
    push_byte(8'h40);
    ticks(40);
    chk("empty_flush_discarded", rx_q.size(), 32'd0);
    pay.delete();
    pay.push_back(8'h40);
    for (int i = 1; i < 16; i++) begin
      push_byte(8'(8'h40 + i));
      pay.push_back(8'(8'h40 + i));
    end
    expect_pkt(8'd4, "after_discard");

    // overflow: fill with tx_rdy low
    ticks(5);
    tx_rdy = 1'b0;
    for (int i = 0; i < 32; i++) push_byte(8'(8'h80 + i));
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("no_overflow_yet", {31'd0, overflow}, 32'd0);
    push_byte(8'hEE);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    chk("held_no_tx", rx_q.size(), 32'd0);
    tx_rdy = 1'b1;
    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'(8'h80 + i));
    expect_pkt(8'd5, "ovf_a");
    pay.delete();
    for (int i = 16; i < 32; i++) pay.push_back(8'(8'h80 + i));
    expect_pkt(8'd6, "ovf_b");
    ticks(60);
    chk("dropped_byte_absent", rx_q.size(), 32'd0);
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);
    chk("pkt_cnt_7", {16'd0, pkt_cnt}, 32'd7);

    // reset after 5th byte of a packet
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    wait_rx(5, 500);
    rst = 1'b1;
    ticks(2);
    chk("midrst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    ticks(60);
    chk("midrst_no_more_tx", rx_q.size(), 32'd5);
    rx_q.delete();
    pay.delete();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(8'h30 + i));
      pay.push_back(8'(8'h30 + i));
    end
    expect_pkt(8'd0, "after_rst");
    ticks(3);
    chk("pkt_cnt_after_rst", {16'd0, pkt_cnt}, 32'd1);

    // 256 more packets: sequence wraps, packet 257 carries seq 0
    for (int k = 1; k <= 256; k++) begin
      pay.delete();
      for (int i = 0; i < 16; i++) begin
        push_byte(8'(k + i));
        pay.push_back(8'(k + i));
      end
      expect_pkt(8'(k), $sformatf("wrap%0d", k));
    end
    ticks(3);
    chk("pkt_cnt_257", {16'd0, pkt_cnt}, 32'd257);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
